// File: rtl/tdm_demux_1xn.sv
// -----------------------------------------------------------------------------
// tdm_demux_1xn
//
// Purpose:
//   Time-division demultiplexer. This is the receiving end of a round-robin
//   word mux. It takes a serial stream of W-bit words, one word per slot,
//   where slot 0 is marked by frame_start. It reassembles each N-slot frame
//   into N parallel lanes and announces every complete frame with a
//   one-cycle dout_valid pulse.
//
// Parameters:
//   W  - word width in bits per slot (W >= 1)
//   N  - slots per frame and number of output lanes (N >= 2)
//   SW - slot counter width, $clog2(N) (local, not overridable)
//
// Ports:
//   clk         in   rising-edge clock for all logic
//   rst         in   synchronous, active-high reset
//   din         in   W-bit serial word for the current slot
//   din_valid   in   din/frame_start are sampled only when high
//   frame_start in   marks the current valid word as slot 0
//   din_par     in   even parity over din (only with TDM_DEMUX_PARITY_EN)
//   dout        out  last complete frame, lane k at dout[k*W +: W]
//   dout_valid  out  one-cycle pulse when dout takes a new frame
//   busy        out  high while a partial frame is being collected
//   slot        out  index of the next expected slot (0 when idle)
//   sync_err    out  one-cycle pulse when frame_start arrives mid-frame
//   par_err     out  any word of the frame on dout failed parity
//                    (only with TDM_DEMUX_PARITY_EN)
//
// Configuration macro:
//   TDM_DEMUX_PARITY_EN - adds din_par/par_err and per-frame parity tracking.
// -----------------------------------------------------------------------------
module tdm_demux_1xn #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           din,
  input  logic                   din_valid,
  input  logic                   frame_start,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic                   din_par,
  output logic                   par_err,
`endif
  output logic [N*W-1:0]         dout,
  output logic                   dout_valid,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   slot,
  output logic                   sync_err
);

  localparam int SW = $clog2(N);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t                  state_r;
  logic [SW-1:0]           slot_r;
  // Only slots 0..N-2 are buffered; the last word goes straight into dout.
  logic [N-2:0][W-1:0]     shadow_r;
  logic [N*W-1:0]          dout_r;
  logic                    dout_valid_r;
  logic                    sync_err_r;

`ifdef TDM_DEMUX_PARITY_EN
  logic                    par_acc_r;
  logic                    par_err_r;
  logic                    word_bad_s;

  // Even parity: din together with din_par must XOR to zero.
  function automatic logic parity_bad(input logic [W-1:0] d, input logic p);
    parity_bad = ^{d, p};
  endfunction

  // Parity check of the word currently presented.
  always_comb begin
    word_bad_s = parity_bad(din, din_par);
  end
`endif

  // Frame collection state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      slot_r       <= {SW{1'b0}};
      shadow_r     <= {((N-1)*W){1'b0}};
      dout_r       <= {(N*W){1'b0}};
      dout_valid_r <= 1'b0;
      sync_err_r   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_acc_r    <= 1'b0;
      par_err_r    <= 1'b0;
`endif
    end else begin
      // Pulses default low; they are raised only on the event beat.
      dout_valid_r <= 1'b0;
      sync_err_r   <= 1'b0;
      if (din_valid) begin
        case (state_r)
          ST_IDLE: begin
            // Hunting: only a frame_start beat is taken, others are dropped.
            if (frame_start) begin
              shadow_r[0] <= din;
              slot_r      <= SW'(1);
              state_r     <= ST_COLLECT;
`ifdef TDM_DEMUX_PARITY_EN
              par_acc_r   <= word_bad_s;
`endif
            end else begin
              state_r     <= ST_IDLE;
            end
          end
          ST_COLLECT: begin
            if (frame_start) begin
              // Resync: drop the partial frame and restart at slot 1.
              sync_err_r  <= 1'b1;
              shadow_r[0] <= din;
              slot_r      <= SW'(1);
`ifdef TDM_DEMUX_PARITY_EN
              par_acc_r   <= word_bad_s;
`endif
            end else if (slot_r == SW'(N-1)) begin
              dout_r       <= {din, shadow_r};
              dout_valid_r <= 1'b1;
              slot_r       <= {SW{1'b0}};
              state_r      <= ST_IDLE;
`ifdef TDM_DEMUX_PARITY_EN
              par_err_r    <= par_acc_r | word_bad_s;
              par_acc_r    <= 1'b0;
`endif
            end else begin
              for (int k = 0; k < N-1; k++) begin
                if (slot_r == SW'(k)) begin
                  shadow_r[k] <= din;
                end
              end
              slot_r <= slot_r + SW'(1);
`ifdef TDM_DEMUX_PARITY_EN
              par_acc_r <= par_acc_r | word_bad_s;
`endif
            end
          end
          default: begin
            state_r <= ST_IDLE;
            slot_r  <= {SW{1'b0}};
          end
        endcase
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign sync_err   = sync_err_r;
  assign slot       = slot_r;
  assign busy       = (state_r == ST_COLLECT);
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err    = par_err_r;
`endif

endmodule

// File: tb/tb_tdm_demux_1xn.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1xn
//
// Self-checking bench for tdm_demux_1xn (W=8, N=4). A frame-level model
// (a queue of words collected since the last frame_start) predicts every
// output; a compare process checks the DUT against it on every falling edge.
// Directed frames pin the model with literal expectations, followed by
// randomized traffic with gaps, resyncs, hunting words and resets.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1xn;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = $clog2(N);

  logic             clk;
  logic             rst;
  logic [W-1:0]     din;
  logic             din_valid;
  logic             frame_start;
  logic [N*W-1:0]   dout;
  logic             dout_valid;
  logic             busy;
  logic [SW-1:0]    slot;
  logic             sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic             din_par;
  logic             par_err;
`endif

  tdm_demux_1xn #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_start(frame_start),
`ifdef TDM_DEMUX_PARITY_EN
    .din_par    (din_par),
    .par_err    (par_err),
`endif
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .slot       (slot),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic bad_par = 1'b0;   // flips din_par away from even parity

  // Model state: words of the frame in progress, plus expected outputs.
  logic [W-1:0]   q[$];
  logic           m_bad;
  logic [N*W-1:0] exp_dout;
  logic           exp_dv;
  logic           exp_se;
  logic           exp_pe;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic pbad;
    pbad = bad_par;
    if (rst) begin
      q.delete();
      exp_dout = '0;
      exp_dv   = 1'b0;
      exp_se   = 1'b0;
      exp_pe   = 1'b0;
      m_bad    = 1'b0;
    end else begin
      exp_dv = 1'b0;
      exp_se = 1'b0;
      if (din_valid) begin
        if (frame_start) begin
          if (q.size() > 0) exp_se = 1'b1;
          q.delete();
          q.push_back(din);
          m_bad = pbad;
        end else if (q.size() > 0) begin
          q.push_back(din);
          m_bad = m_bad | pbad;
          if (q.size() == N) begin
            for (int k = 0; k < N; k++) exp_dout[k*W +: W] = q[k];
            exp_dv = 1'b1;
            exp_pe = m_bad;
            q.delete();
          end
        end
      end
    end
  endtask

  // Advance the model on every rising edge with the inputs it samples.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("dout", 64'(dout), 64'(exp_dout));
        check("dout_valid", 64'(dout_valid), 64'(exp_dv));
        check("sync_err", 64'(sync_err), 64'(exp_se));
        check("busy", 64'(busy), 64'(q.size() > 0));
        check("slot", 64'(slot), 64'(q.size()));
`ifdef TDM_DEMUX_PARITY_EN
        check("par_err", 64'(par_err), 64'(exp_pe));
`endif
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  assign din_par = (^din) ^ bad_par;
`endif

  // One accepted beat; returns 1 time unit after the accepting edge.
  task automatic beat(input logic [W-1:0] d, input logic fs, input logic pb);
    din = d; frame_start = fs; din_valid = 1'b1; bad_par = pb;
    @(posedge clk); #1;
    din_valid = 1'b0; frame_start = 1'b0; bad_par = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_dout", 64'(dout), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_slot", 64'(slot), 64'h0);

    // Basic frame
    beat(8'h11, 1'b1, 1'b0); beat(8'h22, 1'b0, 1'b0);
    beat(8'h33, 1'b0, 1'b0); beat(8'h44, 1'b0, 1'b0);
    check("basic_dout", 64'(dout), 64'h44332211);
    check("basic_dv", 64'(dout_valid), 64'h1);
    check("basic_busy", 64'(busy), 64'h0);
    idle(1);
    check("basic_dv_drop", 64'(dout_valid), 64'h0);

    // Gapped frame
    beat(8'h11, 1'b1, 1'b0); idle(3);
    check("gap_slot", 64'(slot), 64'h1);
    check("gap_busy", 64'(busy), 64'h1);
    beat(8'h22, 1'b0, 1'b0); idle(3);
    beat(8'h33, 1'b0, 1'b0); idle(3);
    check("gap_slot3", 64'(slot), 64'h3);
    beat(8'h44, 1'b0, 1'b0);
    check("gap_dout", 64'(dout), 64'h44332211);
    check("gap_dv", 64'(dout_valid), 64'h1);

    // Hunt
    beat(8'hAA, 1'b0, 1'b0); beat(8'hBB, 1'b0, 1'b0);
    check("hunt_busy", 64'(busy), 64'h0);
    beat(8'h01, 1'b1, 1'b0); beat(8'h02, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0); beat(8'h04, 1'b0, 1'b0);
    check("hunt_dout", 64'(dout), 64'h04030201);

    // Resync
    beat(8'h10, 1'b1, 1'b0); beat(8'h20, 1'b0, 1'b0);
    beat(8'h30, 1'b1, 1'b0);
    check("resync_err", 64'(sync_err), 64'h1);
    check("resync_slot", 64'(slot), 64'h1);
    beat(8'h40, 1'b0, 1'b0);
    check("resync_err_drop", 64'(sync_err), 64'h0);
    beat(8'h50, 1'b0, 1'b0); beat(8'h60, 1'b0, 1'b0);
    check("resync_dout", 64'(dout), 64'h60504030);

    // Back-to-back then reset mid-frame
    beat(8'h01, 1'b1, 1'b0); beat(8'h02, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0); beat(8'h04, 1'b0, 1'b0);
    check("b2b_dout1", 64'(dout), 64'h04030201);
    beat(8'h05, 1'b1, 1'b0); beat(8'h06, 1'b0, 1'b0);
    beat(8'h07, 1'b0, 1'b0); beat(8'h08, 1'b0, 1'b0);
    check("b2b_dout2", 64'(dout), 64'h08070605);
    check("b2b_dv2", 64'(dout_valid), 64'h1);
    beat(8'h09, 1'b1, 1'b0); beat(8'h0A, 1'b0, 1'b0);
    do_reset();
    check("rst_dout", 64'(dout), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_slot", 64'(slot), 64'h0);
    beat(8'hC1, 1'b1, 1'b0); beat(8'hC2, 1'b0, 1'b0);
    beat(8'hC3, 1'b0, 1'b0); beat(8'hC4, 1'b0, 1'b0);
    check("post_rst_dout", 64'(dout), 64'hC4C3C2C1);

`ifdef TDM_DEMUX_PARITY_EN
    beat(8'h5A, 1'b1, 1'b0); beat(8'h6B, 1'b0, 1'b0);
    beat(8'h7C, 1'b0, 1'b1); beat(8'h8D, 1'b0, 1'b0);
    check("par_err_set", 64'(par_err), 64'h1);
    beat(8'h5A, 1'b1, 1'b0); beat(8'h6B, 1'b0, 1'b0);
    beat(8'h7C, 1'b0, 1'b0); beat(8'h8D, 1'b0, 1'b0);
    check("par_err_clr", 64'(par_err), 64'h0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      din_valid   = ($urandom_range(0, 9) < 7);
      frame_start = ($urandom_range(0, 5) == 0);
      din         = W'($urandom);
      bad_par     = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; din_valid = 1'b0; frame_start = 1'b0; bad_par = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1xn.md
Name: tdm_demux_1xn

Overview:
- Time-division demultiplexer: the receiving end of a round-robin word mux.
- Accepts a serial stream of W-bit words, one word per slot, with a frame_start marker on slot 0.
- Reassembles each N-slot frame into N parallel lanes and presents a complete frame with a one-cycle valid pulse.
- Sits downstream of the mux/serializer in the datapath and feeds lane-parallel logic.

Parameters:
W, 8, word width in bits per slot (W >= 1).
N, 4, slots per frame and number of output lanes (N >= 2).
SW, $clog2(N), local parameter: slot counter width, not overridable.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
din  input  W  serial data word for the current slot.
din_valid  input  1  din (and frame_start) are valid this cycle; when low, nothing is sampled.
frame_start  input  1  marks the current valid word as slot 0; ignored when din_valid = 0.
dout  output  N*W  last complete frame; lane k at dout[k*W +: W].
dout_valid  output  1  one-cycle pulse: dout was updated with a new complete frame.
busy  output  1  high while in COLLECT (partial frame held).
slot  output  SW  index of the next expected slot.
sync_err  output  1  one-cycle pulse: frame_start arrived mid-frame.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - state = IDLE, slot = 0, shadow lanes = 0.
  - dout = 0, dout_valid = 0, sync_err = 0, busy = 0.
  - Reset mid-frame discards the partial frame; dout is cleared.
- Accepted beat means din_valid = 1 at a rising edge. Gaps of any length (din_valid = 0) hold all state; there is no timeout.
- IDLE (hunting):
  - Beat with frame_start = 1: shadow[0] <= din, slot <= 1, state -> COLLECT.
  - Beat with frame_start = 0: word discarded, no state change, no error.
- COLLECT, beat with frame_start = 0 and slot < N-1: shadow[slot] <= din, slot <= slot+1.
- COLLECT, beat with frame_start = 0 and slot = N-1:
  - dout <= {din, shadow[N-2..0]}, dout_valid <= 1 for one cycle.
  - slot <= 0, state -> IDLE.
- COLLECT, beat with frame_start = 1 (resync):
  - sync_err <= 1 for one cycle; partial frame dropped; dout unchanged.
  - shadow[0] <= din, slot <= 1, stay COLLECT.
- Latency: dout/dout_valid are registered and update on the same edge that accepts slot N-1, so they are visible the cycle after the last word is presented.
- Back-to-back frames: a frame_start beat in the cycle immediately after the last-slot beat is accepted (state is IDLE) with no bubble. Sustained throughput is N words per frame.
- dout holds its value between completions; dout_valid and sync_err are never high for more than one consecutive cycle per event.
- busy = (state == COLLECT); slot is the registered counter, which is always 0 in IDLE.
- Shadow lanes not yet written in the current frame keep stale data. This is never exposed, because only complete frames reach dout.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- With the macro defined:
  - Adds input din_par (1 bit, even parity over din, sampled with din_valid) and output par_err (1 bit).
  - par_err is a sticky-per-frame flag registered alongside dout: high with dout_valid if any word of that frame failed parity.
  - The flag is cleared at each frame_start accept and on reset.
  - Data is still delivered; parity never blocks output.
- Without the macro: din_par and par_err do not exist; no parity logic.

Test Plan:
- Basic frame, W=8 N=4: after reset, send 0x11 (frame_start) then 0x22, 0x33, 0x44 on consecutive cycles -> one cycle later dout = 0x44332211, dout_valid pulses once, busy low, slot = 0.
- Gapped input: same frame with din_valid low for 3 cycles between each word -> identical dout, a single dout_valid pulse, slot/busy frozen during the gaps.
- Hunt: send 0xAA, 0xBB without frame_start, then a valid frame 0x01..0x04 -> 0xAA/0xBB discarded, dout = 0x04030201, no sync_err.
- Resync: frame_start 0x10, 0x20, then frame_start 0x30, 0x40, 0x50, 0x60 -> sync_err pulses on the third beat, dout = 0x60504030, exactly one dout_valid.
- Back-to-back plus reset: two contiguous frames (0x01..0x04, 0x05..0x08) -> dout_valid pulses 4 cycles apart with the correct values. Then assert rst after 2 words of a third frame -> all outputs 0, state IDLE, and the next full frame decodes correctly.
- Parity (TDM_DEMUX_PARITY_EN): frame with wrong din_par on slot 2 -> par_err = 1 with dout_valid. The next clean frame -> par_err = 0.
